inv: RTL and testbench

INV -- requirements
Module: inv

---
 rtl/inv.sv | 78 +++++++
 tb/tb_inv.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/inv.sv
// One-bit full adder: combinational sum/carry plus a registered stage with a stored
// carry for LSB-first serial addition and a count of accepted bit-additions.
module inv #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c0,
  input  logic             en,
  input  logic             ser,
  input  logic             clr,
  output logic             s,
  output logic             c,
  output logic             s_q,
  output logic             c_q,
  output logic             cy_q,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_wrap
);

  logic             s_reg_q, s_reg_d;
  logic             c_reg_q, c_reg_d;
  logic             cy_reg_q, cy_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             cin_eff;

  assign s = a ^ b ^ c0;
  assign c = (a & b) | (a & c0) | (b & c0);

  // Serial mode chains the previous bit's carry into this one.
  assign cin_eff = ser ? cy_reg_q : c0;

  always_comb begin
    s_reg_d  = s_reg_q;
    c_reg_d  = c_reg_q;
    cy_reg_d = cy_reg_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    if (clr) begin
      s_reg_d  = 1'b0;
      c_reg_d  = 1'b0;
      cy_reg_d = 1'b0;
      cnt_d    = '0;
    end else if (en) begin
      s_reg_d  = a ^ b ^ cin_eff;
      c_reg_d  = (a & b) | (a & cin_eff) | (b & cin_eff);
      cy_reg_d = (a & b) | (a & cin_eff) | (b & cin_eff);
      cnt_d    = cnt_q + 1'b1;
      wrap_d   = &cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg_q  <= 1'b0;
      c_reg_q  <= 1'b0;
      cy_reg_q <= 1'b0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      s_reg_q  <= s_reg_d;
      c_reg_q  <= c_reg_d;
      cy_reg_q <= cy_reg_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  assign s_q      = s_reg_q;
  assign c_q      = c_reg_q;
  assign cy_q     = cy_reg_q;
  assign cnt      = cnt_q;
  assign cnt_wrap = wrap_q;

endmodule

// File: tb/tb_inv.sv
// Directed bench for inv: combinational sweep, serial add, hold, clear, reset and wrap.
module tb_inv;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n, a, b, c0, en, ser, clr;
  logic       s, c, s_q, c_q, cy_q, cnt_wrap;
  logic [7:0] cnt;
  int         tests = 0;
  int         fails = 0;
  int         wraps_seen;

  inv #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c0(c0), .en(en), .ser(ser), .clr(clr),
    .s(s), .c(c), .s_q(s_q), .c_q(c_q), .cy_q(cy_q), .cnt(cnt), .cnt_wrap(cnt_wrap)
  );

  always #5 clk = clk_run ? ~clk : 1'b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic es, input logic ec,
                            input logic ecy, input logic [7:0] ecnt, input logic ew);
    check({tag, ".s_q"}, 32'(s_q), 32'(es));
    check({tag, ".c_q"}, 32'(c_q), 32'(ec));
    check({tag, ".cy_q"}, 32'(cy_q), 32'(ecy));
    check({tag, ".cnt"}, 32'(cnt), 32'(ecnt));
    check({tag, ".wrap"}, 32'(cnt_wrap), 32'(ew));
  endtask

  initial begin
    logic [7:0] s_exp, c_exp, av, bv, sv;
    logic [2:0] v;
    s_exp = 8'b1001_0110;
    c_exp = 8'b1110_1000;
    av    = 8'b0000_1011;
    bv    = 8'b0000_0110;
    sv    = 8'b0000_0001;

    rst_n = 1'b0; a = 1'b0; b = 1'b0; c0 = 1'b0; en = 1'b0; ser = 1'b0; clr = 1'b0;
    #2;
    check_regs("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Combinational sweep with the clock idle.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, c0} = v;
      #1;
      check($sformatf("sweep%0d.s", i), 32'(s), 32'(s_exp[i]));
      check($sformatf("sweep%0d.c", i), 32'(c), 32'(c_exp[i]));
    end

    // Serial 11 + 6, LSB first.
    a = 1'b0; b = 1'b0; c0 = 1'b0;
    rst_n = 1'b1;
    clk_run = 1'b1;
    ser = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = av[i]; b = bv[i];
      tick();
      check($sformatf("serial%0d.s_q", i), 32'(s_q), 32'(sv[i]));
    end
    check("serial.cy_q", 32'(cy_q), 32'd1);
    check("serial.cnt", 32'(cnt), 32'd4);

    // Mid-cycle reset discards the stored carry.
    #2; rst_n = 1'b0; #1;
    check_regs("serial_rst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;

    // Parallel mode with all ones, then hold.
    ser = 1'b0; a = 1'b1; b = 1'b1; c0 = 1'b1; en = 1'b1;
    tick();
    check_regs("par111", 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
    en = 1'b0; a = 1'b0; b = 1'b0; c0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_regs($sformatf("hold%0d", i), 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
    end

    // Build cnt=5, cy_q=1, then clear overrides enable.
    a = 1'b1; b = 1'b1; c0 = 1'b0; en = 1'b1;
    repeat (4) tick();
    check_regs("pre_clr", 1'b0, 1'b1, 1'b1, 8'd5, 1'b0);
    clr = 1'b1;
    tick();
    check_regs("clr", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    clr = 1'b0;

    // Stored carry survives a switch into serial mode.
    a = 1'b1; b = 1'b1; c0 = 1'b0; ser = 1'b0;
    tick();
    a = 1'b0; b = 1'b0; ser = 1'b1;
    tick();
    check_regs("mode_chg", 1'b1, 1'b0, 1'b0, 8'd2, 1'b0);

    // Async reset pulse between edges leaves s/c untouched.
    ser = 1'b0; a = 1'b1; b = 1'b1; c0 = 1'b1;
    tick();
    check("pre_arst.s_q", 32'(s_q), 32'd1);
    #2; rst_n = 1'b0; #1;
    check_regs("arst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check("arst.s", 32'(s), 32'd1);
    check("arst.c", 32'(c), 32'd1);
    #1; rst_n = 1'b1;

    // Counter wrap after 256 accepted updates.
    a = 1'b0; b = 1'b0; c0 = 1'b0; en = 1'b1;
    wraps_seen = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (cnt_wrap === 1'b1) wraps_seen++;
    end
    check("wrap255.cnt", 32'(cnt), 32'd255);
    check("wrap255.pulses", 32'(wraps_seen), 32'd0);
    tick();
    check("wrap256.cnt", 32'(cnt), 32'd0);
    check("wrap256.wrap", 32'(cnt_wrap), 32'd1);
    en = 1'b0;
    tick();
    check("wrap_after.wrap", 32'(cnt_wrap), 32'd0);
    check("wrap_after.cnt", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
